// File: rtl/conv_pkg.sv
// Shared definitions for the conv post-processing stage: default geometry, derived widths,
// and the ReLU / unsigned-max helpers used by the pooling datapath.
package conv_pkg;

    localparam int unsigned D    = 16;
    localparam int unsigned W_IN = 28;
    localparam int unsigned H_IN = 28;
    localparam int unsigned CW   = $clog2(W_IN);
    localparam int unsigned RW   = $clog2(H_IN);
    localparam int unsigned KW   = $clog2(W_IN / 2);

    // Negative samples clamp to zero; everything downstream is unsigned.
    function automatic logic [D-1:0] relu(input logic [D-1:0] y);
        return y[D-1] ? '0 : y;
    endfunction

    function automatic logic [D-1:0] max_u(input logic [D-1:0] a, input logic [D-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_relu_maxpool_if.sv
// Sample stream in from the conv engine and pooled stream out; master drives samples.
interface conv_relu_maxpool_if #(
    parameter int unsigned D = conv_pkg::D
);
    logic [D-1:0] iY;
    logic         iValid;
    logic         iSoF;
    logic [D-1:0] oP;
    logic         oValid;
    logic         oFrameDone;

    modport master (output iY, iValid, iSoF, input  oP, oValid, oFrameDone);
    modport slave  (input  iY, iValid, iSoF, output oP, oValid, oFrameDone);
endinterface

// File: rtl/pool_line_buffer.sv
// One pooled-row of horizontal pair maxima, held between the even and odd rows of a window.
module pool_line_buffer #(
    parameter int unsigned D     = conv_pkg::D,
    parameter int unsigned DEPTH = conv_pkg::W_IN / 2,
    parameter int unsigned KW    = conv_pkg::KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [KW-1:0] wr_idx,
    input  logic [D-1:0]  wr_data,
    input  logic [KW-1:0] rd_idx,
    output logic [D-1:0]  rd_data
);

    logic [D-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/conv_relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over the row-major conv output stream.
module conv_relu_maxpool #(
    parameter int unsigned D    = conv_pkg::D,
    parameter int unsigned W_IN = conv_pkg::W_IN,
    parameter int unsigned H_IN = conv_pkg::H_IN
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    conv_relu_maxpool_if.slave   bus
);

    localparam int unsigned CW = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int unsigned RW = (H_IN > 1) ? $clog2(H_IN) : 1;
    localparam int unsigned KW = (W_IN > 2) ? $clog2(W_IN / 2) : 1;

    if ((W_IN % 2) != 0 || W_IN < 2) begin : g_bad_w_in
        $error("W_IN must be even and >= 2");
    end
    if ((H_IN % 2) != 0 || H_IN < 2) begin : g_bad_h_in
        $error("H_IN must be even and >= 2");
    end
    if (D != conv_pkg::D) begin : g_bad_d
        $error("D must match conv_pkg::D (helper function width)");
    end

    logic [CW-1:0] col_q;
    logic [CW-1:0] col_eff;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_eff;
    logic [D-1:0]  pair_q;
    logic [D-1:0]  relu_c;
    logic [D-1:0]  hmax_c;
    logic [D-1:0]  lb_rd;
    logic [KW-1:0] k_idx;
    logic          last_col;
    logic          last_row;
    logic          lb_wr;

    // Start-of-frame overrides the counters for the current sample only.
    always_comb begin
        col_eff  = bus.iSoF ? '0 : col_q;
        row_eff  = bus.iSoF ? '0 : row_q;
        relu_c   = conv_pkg::relu(bus.iY);
        hmax_c   = conv_pkg::max_u(pair_q, relu_c);
        k_idx    = KW'(col_eff >> 1);
        last_col = (col_eff == CW'(W_IN - 1));
        last_row = (row_eff == RW'(H_IN - 1));
        lb_wr    = bus.iValid & col_eff[0] & ~row_eff[0];
    end

    pool_line_buffer #(
        .D     (D),
        .DEPTH (W_IN / 2),
        .KW    (KW)
    ) u_lbuf (
        .clk     (iCLK),
        .rst_n   (iRSTn),
        .wr_en   (lb_wr),
        .wr_idx  (k_idx),
        .wr_data (hmax_c),
        .rd_idx  (k_idx),
        .rd_data (lb_rd)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            col_q          <= '0;
            row_q          <= '0;
            pair_q         <= '0;
            bus.oP         <= '0;
            bus.oValid     <= 1'b0;
            bus.oFrameDone <= 1'b0;
        end else begin
            bus.oValid     <= 1'b0;
            bus.oFrameDone <= 1'b0;
            if (bus.iValid) begin
                if (!col_eff[0]) begin
                    pair_q <= relu_c;
                end else if (row_eff[0]) begin
                    bus.oP         <= conv_pkg::max_u(lb_rd, hmax_c);
                    bus.oValid     <= 1'b1;
                    bus.oFrameDone <= last_col & last_row;
                end
                // Raster advance with row wrap at the end of the frame.
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_eff + RW'(1);
                end else begin
                    col_q <= col_eff + CW'(1);
                    row_q <= row_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Scoreboard bench for conv_relu_maxpool: directed frames push expected windows, a monitor checks them.
module tb_conv_relu_maxpool;

    typedef struct {
        logic [15:0] p;
        bit          fd;
        longint      cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    longint cyc = 0;
    int     n_pass = 0;
    int     n_total = 0;
    exp_t   sb[$];
    longint fd_cyc[$];

    conv_relu_maxpool_if #(.D(16)) bus ();

    conv_relu_maxpool dut (
        .iCLK  (clk),
        .iRSTn (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Sample value at (r,c): mode 0 ramp, 1 ramp with ReLU/ordering specials, 2 reversed ramp.
    function automatic logic [15:0] val(input int mode, input int r, input int c);
        if (mode == 1 && r == 0 && c == 0) return 16'hFFFF;
        if (mode == 1 && r == 0 && c == 1) return 16'h8000;
        if (mode == 1 && r == 1 && c == 0) return 16'hFFFB;
        if (mode == 1 && r == 1 && c == 1) return 16'hFF38;
        if (mode == 1 && r == 0 && c == 2) return 16'hFFF9;
        if (mode == 1 && r == 0 && c == 3) return 16'h0003;
        if (mode == 1 && r == 1 && c == 2) return 16'h7FFF;
        if (mode == 1 && r == 1 && c == 3) return 16'hFFFF;
        if (mode == 1 && r == 0 && c == 4) return 16'h4000;
        if (mode == 1 && r == 0 && c == 7) return 16'h2000;
        if (mode == 2) return 16'((27 - r) * 28 + (27 - c));
        return 16'(r * 28 + c);
    endfunction

    // Hand-derived window maximum at completing sample (r,c), both odd.
    function automatic logic [15:0] expv(input int mode, input int r, input int c);
        if (mode == 1 && r == 1 && c == 1) return 16'h0000;
        if (mode == 1 && r == 1 && c == 3) return 16'h7FFF;
        if (mode == 1 && r == 1 && c == 5) return 16'h4000;
        if (mode == 1 && r == 1 && c == 7) return 16'h2000;
        if (mode == 2) return 16'((28 - r) * 28 + (28 - c));
        return 16'(r * 28 + c);
    endfunction

    task automatic send(input logic [15:0] y, input bit sof, input bit has,
                        input logic [15:0] ep, input bit efd);
        exp_t e;
        bus.iY     = y;
        bus.iValid = 1'b1;
        bus.iSoF   = sof;
        if (has) begin
            e.p   = ep;
            e.fd  = efd;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.iValid = 1'b0;
        bus.iSoF   = 1'b0;
    endtask

    task automatic frame(input int mode, input int duty, input bit sof_first, input int n);
        for (int idx = 0; idx < n; idx++) begin
            int r;
            int c;
            r = idx / 28;
            c = idx % 28;
            if (duty < 100)
                while ($urandom_range(99) >= duty) @(negedge clk);
            send(val(mode, r, c), sof_first && idx == 0, (r % 2 == 1) && (c % 2 == 1),
                 expv(mode, r, c), (r == 27) && (c == 27));
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard in value, flag and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.oFrameDone === 1'b1) fd_cyc.push_back(cyc);
            if (bus.oValid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("oP@%0d", e.cyc), longint'(bus.oP), longint'(e.p));
                    chk($sformatf("oFrameDone@%0d", e.cyc), longint'(bus.oFrameDone), longint'(e.fd));
                    chk($sformatf("latency@%0d", e.cyc), cyc, e.cyc);
                end
            end else if (bus.oFrameDone === 1'b1) begin
                chk("stray_frame_done", 1, 0);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        bus.iY     = '0;
        bus.iValid = 1'b0;
        bus.iSoF   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_oP", longint'(bus.oP), 0);
        chk("reset_oValid", longint'(bus.oValid), 0);
        chk("reset_oFrameDone", longint'(bus.oFrameDone), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial frame up to the first window, then reset while the strobe is still high.
        frame(0, 100, 1'b1, 30);
        #2;
        chk("pre_reset_oValid", longint'(bus.oValid), 1);
        chk("pre_reset_oP", longint'(bus.oP), 29);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_oP", longint'(bus.oP), 0);
        chk("mid_reset_oValid", longint'(bus.oValid), 0);
        chk("mid_reset_oFrameDone", longint'(bus.oFrameDone), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ReLU frame starting from the post-reset (0,0), no iSoF.
        frame(1, 100, 1'b0, 784);
        // Dense ramp frame.
        frame(0, 100, 1'b1, 784);
        // Ramp with ~30% valid duty.
        frame(0, 30, 1'b1, 784);
        // Resync: iSoF on sample 100 of a frame restarts the raster.
        frame(0, 100, 1'b1, 100);
        frame(0, 100, 1'b1, 784);
        repeat (3) @(negedge clk);

        // Back-to-back frames: ramp then reversed ramp, no idle between them.
        fd_cyc.delete();
        frame(0, 100, 1'b1, 784);
        frame(2, 100, 1'b0, 784);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_pending", longint'(sb.size()), 0);
        chk("b2b_frame_done_count", longint'(fd_cyc.size()), 2);
        if (fd_cyc.size() == 2) chk("b2b_frame_done_spacing", fd_cyc[1] - fd_cyc[0], 784);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
